// File: rtl/axi_mst_pkg.sv
// Shared types, constants and the data-pattern function for the AXI4 master traffic generator.
package axi_mst_pkg;

    localparam int AXI_DW     = 128;
    localparam int AXI_AW     = 40;
    localparam int AXI_IW     = 8;
    localparam int AXI_LW     = 8;
    localparam int AXI_SW     = 3;
    localparam int AXI_BURSTW = 2;
    localparam int AXI_BRESPW = 2;
    localparam int AXI_RRESPW = 2;
    localparam int AXI_BYTES  = AXI_DW / 8;

    localparam logic [AXI_IW-1:0]     MST_ID      = '0;
    localparam logic [AXI_SW-1:0]     AXI_SIZE    = AXI_SW'($clog2(AXI_BYTES));
    localparam logic [AXI_BURSTW-1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam int                    BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    // Beat k of a burst: byte lane i carries (addr + k*AXI_BYTES + i) mod 256.
    // Only the low address byte matters because the pattern wraps every 256 bytes.
    function automatic logic [AXI_DW-1:0] pattern_beat(input logic [7:0]        addr,
                                                       input logic [AXI_LW-1:0] k);
        logic [AXI_DW-1:0] data;
        logic [7:0]        base;
        base = addr + 8'(k * AXI_BYTES);
        data = '0;
        for (int i = 0; i < AXI_BYTES; i++) begin
            data[8*i +: 8] = base + 8'(i);
        end
        return data;
    endfunction

endpackage

// File: rtl/axi_master_model.sv
// Directed AXI4 master: one write or read INCR burst per command, address-derived
// write data, read data checked against the same pattern.
module axi_master_model
    import axi_mst_pkg::*;
(
    input  logic                   ACLK,
    input  logic                   ARESETn,
    // command interface
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [AXI_AW-1:0]      cmd_addr,
    input  logic [AXI_LW-1:0]      cmd_len,
    output logic                   done,
    output logic                   done_err,
    output logic [31:0]            mismatch_cnt,
    // AW channel
    output logic [AXI_IW-1:0]      AWID,
    output logic [AXI_AW-1:0]      AWADDR,
    output logic [AXI_LW-1:0]      AWLEN,
    output logic [AXI_SW-1:0]      AWSIZE,
    output logic [AXI_BURSTW-1:0]  AWBURST,
    output logic                   AWLOCK,
    output logic [3:0]             AWCACHE,
    output logic [2:0]             AWPROT,
    output logic [3:0]             AWQOS,
    output logic [3:0]             AWREGION,
    output logic                   AWVALID,
    input  logic                   AWREADY,
    // W channel
    output logic [AXI_DW-1:0]      WDATA,
    output logic [AXI_BYTES-1:0]   WSTRB,
    output logic                   WLAST,
    output logic                   WVALID,
    input  logic                   WREADY,
    // B channel
    input  logic [AXI_IW-1:0]      BID,
    input  logic [AXI_BRESPW-1:0]  BRESP,
    input  logic                   BVALID,
    output logic                   BREADY,
    // AR channel
    output logic [AXI_IW-1:0]      ARID,
    output logic [AXI_AW-1:0]      ARADDR,
    output logic [AXI_LW-1:0]      ARLEN,
    output logic [AXI_SW-1:0]      ARSIZE,
    output logic [AXI_BURSTW-1:0]  ARBURST,
    output logic                   ARLOCK,
    output logic [3:0]             ARCACHE,
    output logic [2:0]             ARPROT,
    output logic [3:0]             ARQOS,
    output logic [3:0]             ARREGION,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    // R channel
    input  logic [AXI_IW-1:0]      RID,
    input  logic [AXI_DW-1:0]      RDATA,
    input  logic [AXI_RRESPW-1:0]  RRESP,
    input  logic                   RLAST,
    input  logic                   RVALID,
    output logic                   RREADY
);

    state_t              r_state;
    logic                r_cmd_ready;
    logic [AXI_AW-1:0]   r_addr;
    logic [AXI_LW-1:0]   r_len;
    logic [AXI_LW-1:0]   r_beat;
    logic                r_err;
    logic                r_done;
    logic                r_done_err;
    logic [31:0]         r_mismatch_cnt;
    logic                r_awvalid;
    logic                r_arvalid;
    logic                r_wvalid;
    logic [AXI_DW-1:0]   r_wdata;
    logic                r_wlast;
    logic                r_bready;
    logic                r_rready;

    logic [AXI_AW-1:0]   w_addr_aligned;
    logic [31:0]         w_span_end;
    logic                w_cross_4k;
    logic [AXI_LW-1:0]   w_beat_next;
    logic                w_last_beat;
    logic [AXI_DW-1:0]   w_pattern;
    logic                w_r_mismatch;
    logic                w_r_err;
    logic                w_b_err;

    assign w_addr_aligned = cmd_addr & ~AXI_AW'(AXI_BYTES - 1);
    // A burst may end exactly on the 4 KB line but must not run past it.
    assign w_span_end     = 32'(w_addr_aligned[11:0]) + (32'(cmd_len) + 32'd1) * 32'(AXI_BYTES);
    assign w_cross_4k     = (w_span_end > 32'(BOUNDARY_4K));

    assign w_beat_next    = r_beat + AXI_LW'(1);
    assign w_last_beat    = (r_beat == r_len);
    assign w_pattern      = pattern_beat(r_addr[7:0], r_beat);
    assign w_r_mismatch   = (RDATA != w_pattern);
    assign w_r_err        = (RRESP != RESP_OKAY) || (RID != MST_ID) || (RLAST != w_last_beat);
    assign w_b_err        = (BRESP != RESP_OKAY) || (BID != MST_ID);

    // Command sequencer: single-state-register FSM that also owns every bus output.
    always_ff @(posedge ACLK) begin
        // NOTE: reset is sampled on the rising edge, so ARESETn must stay low across at least one edge.
        if (!ARESETn) begin
            r_state        <= S_IDLE;
            r_cmd_ready    <= 1'b0;
            r_addr         <= '0;
            r_len          <= '0;
            r_beat         <= '0;
            r_err          <= 1'b0;
            r_done         <= 1'b0;
            r_done_err     <= 1'b0;
            r_mismatch_cnt <= '0;
            r_awvalid      <= 1'b0;
            r_arvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_wdata        <= '0;
            r_wlast        <= 1'b0;
            r_bready       <= 1'b0;
            r_rready       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every branch below reads the pre-edge register values.
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= w_addr_aligned;
                        r_len       <= cmd_len;
                        r_beat      <= '0;
                        if (w_cross_4k) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_done_err <= 1'b1;
                        end else if (cmd_write) begin
                            r_state   <= S_WADDR;
                            r_awvalid <= 1'b1;
                        end else begin
                            r_state   <= S_RADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_WADDR: begin
                    if (AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= pattern_beat(r_addr[7:0], '0);
                        r_wlast   <= (r_len == '0);
                        r_state   <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (WREADY) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= S_WRESP;
                        end else begin
                            r_beat  <= w_beat_next;
                            r_wdata <= pattern_beat(r_addr[7:0], w_beat_next);
                            r_wlast <= (w_beat_next == r_len);
                        end
                    end
                end
                S_WRESP: begin
                    if (BVALID) begin
                        r_bready   <= 1'b0;
                        r_done     <= 1'b1;
                        r_done_err <= r_err | w_b_err;
                        r_state    <= S_DONE;
                    end
                end
                S_RADDR: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (RVALID) begin
                        if (w_r_mismatch && (r_mismatch_cnt != '1)) begin
                            r_mismatch_cnt <= r_mismatch_cnt + 32'd1;
                        end
                        // The burst length is ours; an early RLAST only flags an error.
                        if (w_last_beat) begin
                            r_rready   <= 1'b0;
                            r_done     <= 1'b1;
                            r_done_err <= r_err | w_r_err;
                            r_state    <= S_DONE;
                        end else begin
                            r_err  <= r_err | w_r_err;
                            r_beat <= w_beat_next;
                        end
                    end
                end
                S_DONE: begin
                    r_err       <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign done         = r_done;
    assign done_err     = r_done_err;
    assign mismatch_cnt = r_mismatch_cnt;

    assign AWID     = MST_ID;
    assign AWADDR   = r_addr;
    assign AWLEN    = r_len;
    assign AWSIZE   = AXI_SIZE;
    assign AWBURST  = BURST_INCR;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'b0;
    assign AWPROT   = 3'b0;
    assign AWQOS    = 4'b0;
    assign AWREGION = 4'b0;
    assign AWVALID  = r_awvalid;

    assign WDATA    = r_wdata;
    assign WSTRB    = '1;
    assign WLAST    = r_wlast;
    assign WVALID   = r_wvalid;
    assign BREADY   = r_bready;

    assign ARID     = MST_ID;
    assign ARADDR   = r_addr;
    assign ARLEN    = r_len;
    assign ARSIZE   = AXI_SIZE;
    assign ARBURST  = BURST_INCR;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'b0;
    assign ARPROT   = 3'b0;
    assign ARQOS    = 4'b0;
    assign ARREGION = 4'b0;
    assign ARVALID  = r_arvalid;
    assign RREADY   = r_rready;

endmodule

// File: doc/axi_master_model.md
# axi_master_model

Directed AXI4 master traffic generator for simulation and bring-up, driving the AXI slave port of the SRAM-backed slave model in the testbench. It accepts one user command at a time: a write or a read INCR burst at a given address and length. Write data comes from a deterministic address-derived pattern. Read data is checked against the same pattern. Per-command status and a cumulative mismatch count are reported to the testbench.

## Interface
- AXI_DW, 128, data bus width (multiple of 8).
- AXI_AW, 40, address width.
- AXI_IW, 8, ID width.
- AXI_LW, 8, AxLEN width.
- AXI_SW, 3, AxSIZE width.
- AXI_BURSTW, 2, AxBURST width.
- AXI_BRESPW / AXI_RRESPW, 2, response widths.
- MST_ID, 0, constant AWID/ARID value.
- AXI_BYTES, AXI_DW/8, derived bytes per beat.
- ACLK  in  1  clock; the block uses one clock.
- ARESETn  in  1  reset, synchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AXI_AW  byte address; low log2(AXI_BYTES) bits are forced to 0.
- cmd_len  in  AXI_LW  beats minus 1.
- done  out  1  one-cycle pulse when the command completes.
- done_err  out  1  valid with done: non-OKAY response, ID/RLAST protocol error, or rejected command.
- mismatch_cnt  out  32  cumulative count of read beats whose data differs from the pattern; saturating.
- AW channel outputs: AWID[AXI_IW], AWADDR[AXI_AW], AWLEN[AXI_LW], AWSIZE[AXI_SW], AWBURST[AXI_BURSTW], AWVALID. AWREADY is an input.
- AW sideband outputs AWLOCK, AWCACHE[4], AWPROT[3], AWQOS[4], AWREGION[4]: constant 0.
- W channel outputs: WDATA[AXI_DW], WSTRB[AXI_BYTES] (all ones), WLAST, WVALID. WREADY is an input.
- B channel inputs: BID[AXI_IW], BRESP[AXI_BRESPW], BVALID. BREADY is an output.
- AR channel: same signal set as AW with the AR prefix, same constant sideband values.
- R channel inputs: RID[AXI_IW], RDATA[AXI_DW], RRESP[AXI_RRESPW], RLAST, RVALID. RREADY is an output.

## Operation
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- cmd_ready is high only in IDLE.
- On command accept:
  - If the burst crosses a 4 KB boundary, go to DONE with done_err = 1. No bus activity occurs. The crossing test is ((addr & 0xFFF) + (len+1)*AXI_BYTES > 0x1000).
  - Otherwise go to WADDR or RADDR and latch the address, length and direction.
- Fixed burst attributes: AxSIZE = log2(AXI_BYTES), AxBURST = INCR (2'b01).
- WADDR: hold AWVALID until AWREADY, then go to WDATA. W beats are never issued before the AW handshake completes.
- WDATA: beat counter k runs from 0 to len.
  - Byte lane i of beat k = (addr + k*AXI_BYTES + i) mod 256.
  - WLAST = (k == len).
  - After the handshake on the WLAST beat, go to WRESP.
- WRESP: BREADY = 1. On BVALID, set the error flag if BRESP != OKAY or BID != MST_ID, then go to DONE.
- RADDR / RDATA: AR handshake follows the same rule as AW. In RDATA, RREADY = 1.
- Each accepted R beat:
  - Compare RDATA with the pattern for beat k and increment mismatch_cnt on any differing bit.
  - Set the error flag on RRESP != OKAY, RID != MST_ID, or RLAST != (k == len).
- RDATA leaves after the beat where k == len. An early RLAST does not terminate the burst; it only sets the error flag.
- DONE: pulse done for one cycle with done_err = error flag, clear the flag, return to IDLE.
- mismatch_cnt is cleared only by reset.

## Timing
- Reset values: every VALID/READY output 0, done 0, done_err 0, mismatch_cnt 0, state IDLE, address/data outputs 0. cmd_ready becomes 1 in the first cycle after reset is released.
- All outputs are registered.
- AxVALID rises in the cycle after command accept.
- Once a VALID is asserted, it and its payload stay stable until the matching READY is sampled high.
- A W beat advances on every cycle where WVALID and WREADY are both high. Back-to-back beats run with no bubble.
- done is asserted in the cycle after the final B handshake or the final R handshake.
- A rejected command pulses done in the cycle after accept.
- Minimum command-to-command spacing: 2 idle cycles (DONE, then IDLE).
- Reset asserted mid-burst: at the next edge all VALIDs/READYs drop and state returns to IDLE. No done pulse is produced. The testbench must also reset the slave.

## Structure
- Shared package axi_mst_pkg holds:
  - the state enum;
  - the constants BURST_INCR = 2'b01, RESP_OKAY = 2'b00, BOUNDARY_4K = 4096;
  - a function pattern_beat(addr, k) that returns the AXI_DW-bit expected/write data.
- No sub-module is needed. The pattern function is shared by the write and read paths, which keeps them bit-identical.

## Test plan
- Write addr 0x100, len 3, slave always ready -> one AW handshake with AWLEN = 3. Beat 0 WDATA bytes are 0x00..0x0F (lane 0 = 0x00). WLAST only on beat 3. done with done_err = 0.
- Read back addr 0x100, len 3 -> ARLEN = 3, four R beats accepted, mismatch_cnt stays 0, done_err = 0.
- Write with random WREADY/AWREADY stalls of 0–5 cycles -> WDATA/WLAST stable throughout every stall, exactly 4 W handshakes. A subsequent read gives mismatch_cnt = 0.
- Slave responds BRESP = SLVERR; separately, one corrupted RDATA beat -> done_err = 1 for the SLVERR write; mismatch_cnt increments by exactly 1 for the corrupted beat.
- Command addr 0xFF0, len 1 (2 beats of 16 B) -> no AWVALID, done with done_err = 1 in the cycle after accept.
- ARESETn low during write beat 2 of 8 -> WVALID/AWVALID = 0 at the next edge, no done pulse, cmd_ready = 1 after release.
